// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Greedy dime/nickel(/penny) payout to a coin hopper over a
//                valid/ready handshake, with saturating hopper inventory.
//                Optional macro PENNY_CHANGE_EN adds penny change.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int               AMT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [CNT_W-1:0] NICKEL_INIT = CNT_W'(20),
    parameter logic [CNT_W-1:0] DIME_INIT   = CNT_W'(20)
`ifdef PENNY_CHANGE_EN
    ,
    parameter logic [CNT_W-1:0] PENNY_INIT  = CNT_W'(50)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic [1:0]       coin,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] residual,
    input  logic             restock_n,
    input  logic             restock_d,
    output logic [CNT_W-1:0] nickels,
    output logic [CNT_W-1:0] dimes
`ifdef PENNY_CHANGE_EN
    ,
    input  logic             restock_p,
    output logic [CNT_W-1:0] pennies
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OFFER  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [1:0] C_PENNY  = 2'd0;
    localparam logic [1:0] C_NICKEL = 2'd1;
    localparam logic [1:0] C_DIME   = 2'd2;

    state_t           r_state;
    logic [AMT_W-1:0] r_rem;
    logic [AMT_W-1:0] w_coin_val;
    logic             w_xfer;
    logic             w_take_n;
    logic             w_take_d;

    assign w_xfer   = coin_valid & coin_ready;
    assign w_take_n = w_xfer && (coin == C_NICKEL);
    assign w_take_d = w_xfer && (coin == C_DIME);

    always_comb begin
        w_coin_val = AMT_W'(1);
        case (coin)
            C_NICKEL: w_coin_val = AMT_W'(5);
            C_DIME:   w_coin_val = AMT_W'(10);
            default:  w_coin_val = AMT_W'(1);
        endcase
    end

    // Simultaneous restock and payout of one denomination cancel out.
    function automatic logic [CNT_W-1:0] f_next(input logic [CNT_W-1:0] cnt,
                                                input logic add, input logic sub);
        if (add && !sub)
            return (&cnt) ? cnt : cnt + CNT_W'(1);
        if (sub && !add)
            return cnt - CNT_W'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickels <= NICKEL_INIT;
            dimes   <= DIME_INIT;
        end else begin
            nickels <= f_next(nickels, restock_n, w_take_n);
            dimes   <= f_next(dimes, restock_d, w_take_d);
        end
    end

`ifdef PENNY_CHANGE_EN
    logic w_take_p;
    assign w_take_p = w_xfer && (coin == C_PENNY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pennies <= PENNY_INIT;
        else
            pennies <= f_next(pennies, restock_p, w_take_p);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            busy       <= 1'b0;
            coin       <= C_PENNY;
            coin_valid <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            residual   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_rem   <= amount;
                        busy    <= 1'b1;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    if (r_rem >= AMT_W'(10) && dimes != '0) begin
                        coin       <= C_DIME;
                        coin_valid <= 1'b1;
                        r_state    <= OFFER;
                    end else if (r_rem >= AMT_W'(5) && nickels != '0) begin
                        coin       <= C_NICKEL;
                        coin_valid <= 1'b1;
                        r_state    <= OFFER;
`ifdef PENNY_CHANGE_EN
                    end else if (r_rem != '0 && pennies != '0) begin
                        coin       <= C_PENNY;
                        coin_valid <= 1'b1;
                        r_state    <= OFFER;
`endif
                    end else begin
                        done     <= 1'b1;
                        residual <= r_rem;
                        short    <= (r_rem != '0);
                        r_state  <= FINISH;
                    end
                end
                OFFER: begin
                    if (coin_ready) begin
                        coin_valid <= 1'b0;
                        r_rem      <= r_rem - w_coin_val;
                        r_state    <= SELECT;
                    end
                end
                FINISH: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
